// File: rtl/periph_bus_bridge_pkg.sv
// Shared definitions for the peripheral bus bridge: FSM state encoding and
// the fill patterns returned to the CPU on faulted reads.
package periph_bus_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   localparam int unsigned FILL_W = 64;

   // Timed-out reads return all ones; reads of unmapped channels return all zeros.
   localparam logic [FILL_W-1:0] RD_FILL_TIMEOUT  = '1;
   localparam logic [FILL_W-1:0] RD_FILL_UNMAPPED = '0;

endpackage

// File: rtl/periph_addr_decode.sv
// Splits a CPU peripheral address into a channel index and flags whether
// that index addresses an implemented channel.
module periph_addr_decode
   import periph_bus_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned SLOT_W = 6,
   parameter int unsigned N_CH   = 4,
   parameter int unsigned IDX_W  = ADDR_W - SLOT_W
) (
   input  logic [ADDR_W-1:0] addr_i,
   output logic [IDX_W-1:0]  ch_idx_c,
   output logic              mapped_c
);

   always_comb begin
      ch_idx_c = addr_i[ADDR_W-1:SLOT_W];
      mapped_c = (32'(ch_idx_c) < N_CH);
   end

endmodule

// File: rtl/periph_bus_bridge.sv
// Bridges a single-outstanding CPU peripheral request onto one of N_CH
// channel buses, with timeout, unmapped-address and conflict error handling.
module periph_bus_bridge
   import periph_bus_bridge_pkg::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned SLOT_W  = 6,
   parameter int unsigned N_CH    = 4,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [ADDR_W-1:0]        i_peripAddr,
   input  logic [DATA_W-1:0]        i_peripDataFromCPU,
   input  logic                     i_peripWrSig,
   input  logic                     i_peripRdSig,
   output logic [DATA_W-1:0]        o_peripDataToCPU,
   output logic                     o_peripStall,
   output logic                     o_peripDone,
   output logic                     o_peripErr,
   output logic [N_CH-1:0]          o_chWrSig,
   output logic [N_CH-1:0]          o_chRdSig,
   output logic [SLOT_W-1:0]        o_chAddr,
   output logic [DATA_W-1:0]        o_chData,
   input  logic [N_CH*DATA_W-1:0]   i_chData,
   input  logic [N_CH-1:0]          i_chReady
);

   localparam int unsigned IDX_W = ADDR_W - SLOT_W;
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [DATA_W-1:0] RD_TIMEOUT  = DATA_W'(RD_FILL_TIMEOUT);
   localparam logic [DATA_W-1:0] RD_UNMAPPED = DATA_W'(RD_FILL_UNMAPPED);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    sel_q, sel_d;
   logic                is_rd_q, is_rd_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                stall_q, stall_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [N_CH-1:0]     wr_strb_q, wr_strb_d;
   logic [N_CH-1:0]     rd_strb_q, rd_strb_d;

   logic [IDX_W-1:0]    dec_idx_c;
   logic                dec_mapped_c;
   logic [N_CH-1:0]     dec_oh_c;
   logic [N_CH-1:0]     sel_oh_c;
   logic                sel_rdy_c;
   logic [DATA_W-1:0]   sel_rdata_c;

   periph_addr_decode #(
      .ADDR_W (ADDR_W),
      .SLOT_W (SLOT_W),
      .N_CH   (N_CH),
      .IDX_W  (IDX_W)
   ) u_decode (
      .addr_i   (i_peripAddr),
      .ch_idx_c (dec_idx_c),
      .mapped_c (dec_mapped_c)
   );

   // One-hot views of the decoded and latched channel, plus the latched channel's return path.
   always_comb begin
      dec_oh_c    = '0;
      sel_oh_c    = '0;
      sel_rdy_c   = 1'b0;
      sel_rdata_c = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         if (dec_idx_c == IDX_W'(k)) begin
            dec_oh_c[k] = 1'b1;
         end
         if (sel_q == IDX_W'(k)) begin
            sel_oh_c[k] = 1'b1;
            sel_rdy_c   = i_chReady[k];
            sel_rdata_c = i_chData[k*DATA_W +: DATA_W];
         end
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sel_d     = sel_q;
      is_rd_d   = is_rd_q;
      slot_d    = slot_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      stall_d   = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      wr_strb_d = '0;
      rd_strb_d = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (i_peripWrSig && i_peripRdSig) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end else if (i_peripWrSig || i_peripRdSig) begin
               if (!dec_mapped_c) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  if (i_peripRdSig) begin
                     rdata_d = RD_UNMAPPED;
                  end
               end else begin
                  state_d   = ST_ACCESS;
                  cnt_d     = CNT_W'(1);
                  sel_d     = dec_idx_c;
                  is_rd_d   = i_peripRdSig;
                  slot_d    = i_peripAddr[SLOT_W-1:0];
                  wdata_d   = i_peripDataFromCPU;
                  stall_d   = 1'b1;
                  wr_strb_d = i_peripWrSig ? dec_oh_c : '0;
                  rd_strb_d = i_peripRdSig ? dec_oh_c : '0;
               end
            end
         end
         ST_ACCESS: begin
            if (sel_rdy_c) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               done_d  = 1'b1;
               if (is_rd_q) begin
                  rdata_d = sel_rdata_c;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT)) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               done_d  = 1'b1;
               err_d   = 1'b1;
               if (is_rd_q) begin
                  rdata_d = RD_TIMEOUT;
               end
            end else begin
               cnt_d     = cnt_q + CNT_W'(1);
               stall_d   = 1'b1;
               wr_strb_d = is_rd_q ? '0 : sel_oh_c;
               rd_strb_d = is_rd_q ? sel_oh_c : '0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         sel_q     <= '0;
         is_rd_q   <= 1'b0;
         slot_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         stall_q   <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         wr_strb_q <= '0;
         rd_strb_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         is_rd_q   <= is_rd_d;
         slot_q    <= slot_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         stall_q   <= stall_d;
         done_q    <= done_d;
         err_q     <= err_d;
         wr_strb_q <= wr_strb_d;
         rd_strb_q <= rd_strb_d;
      end
   end

   assign o_peripDataToCPU = rdata_q;
   assign o_peripStall     = stall_q;
   assign o_peripDone      = done_q;
   assign o_peripErr       = err_q;
   assign o_chWrSig        = wr_strb_q;
   assign o_chRdSig        = rd_strb_q;
   assign o_chAddr         = slot_q;
   assign o_chData         = wdata_q;

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Self-checking bench for periph_bus_bridge: scoreboarded transactions on a
// 4-channel instance plus error-path checks on a 2-channel instance.
module tb_periph_bus_bridge;

   typedef struct packed {
      logic       err;
      logic [7:0] data;
   } exp_t;

   logic        i_clk;
   logic        i_rst;
   logic [7:0]  i_peripAddr;
   logic [7:0]  i_peripDataFromCPU;
   logic        i_peripWrSig;
   logic        i_peripRdSig;
   logic [7:0]  o_peripDataToCPU;
   logic        o_peripStall;
   logic        o_peripDone;
   logic        o_peripErr;
   logic [3:0]  o_chWrSig;
   logic [3:0]  o_chRdSig;
   logic [5:0]  o_chAddr;
   logic [7:0]  o_chData;
   logic [31:0] i_chData;
   logic [3:0]  i_chReady;

   logic [7:0]  b_addr;
   logic [7:0]  b_wdata;
   logic        b_wr;
   logic        b_rd;
   logic [7:0]  b_rdata;
   logic        b_stall;
   logic        b_done;
   logic        b_err;
   logic [1:0]  b_chWr;
   logic [1:0]  b_chRd;
   logic [5:0]  b_chAddr;
   logic [7:0]  b_chData;
   logic [15:0] b_chDataIn;
   logic [1:0]  b_chReady;

   int   n_checks;
   int   n_errors;
   exp_t sb_q[$];
   exp_t sb_e;

   periph_bus_bridge dut (
      .i_clk              (i_clk),
      .i_rst              (i_rst),
      .i_peripAddr        (i_peripAddr),
      .i_peripDataFromCPU (i_peripDataFromCPU),
      .i_peripWrSig       (i_peripWrSig),
      .i_peripRdSig       (i_peripRdSig),
      .o_peripDataToCPU   (o_peripDataToCPU),
      .o_peripStall       (o_peripStall),
      .o_peripDone        (o_peripDone),
      .o_peripErr         (o_peripErr),
      .o_chWrSig          (o_chWrSig),
      .o_chRdSig          (o_chRdSig),
      .o_chAddr           (o_chAddr),
      .o_chData           (o_chData),
      .i_chData           (i_chData),
      .i_chReady          (i_chReady)
   );

   periph_bus_bridge #(.N_CH(2)) dut2 (
      .i_clk              (i_clk),
      .i_rst              (i_rst),
      .i_peripAddr        (b_addr),
      .i_peripDataFromCPU (b_wdata),
      .i_peripWrSig       (b_wr),
      .i_peripRdSig       (b_rd),
      .o_peripDataToCPU   (b_rdata),
      .o_peripStall       (b_stall),
      .o_peripDone        (b_done),
      .o_peripErr         (b_err),
      .o_chWrSig          (b_chWr),
      .o_chRdSig          (b_chRd),
      .o_chAddr           (b_chAddr),
      .o_chData           (b_chData),
      .i_chData           (b_chDataIn),
      .i_chReady          (b_chReady)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Completions on the 4-channel instance are matched against queued expectations.
   always @(negedge i_clk) begin
      if (i_rst && o_peripDone) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_done", 32'd1, 32'd0);
         end else begin
            sb_e = sb_q.pop_front();
            chk("sb_err", 32'(o_peripErr), 32'(sb_e.err));
            chk("sb_rdata", 32'(o_peripDataToCPU), 32'(sb_e.data));
         end
      end
      if (o_peripErr && !o_peripDone) begin
         chk("err_without_done", 32'd1, 32'd0);
      end
   end

   task automatic run_txn(input string tag, input logic wr, input logic rd,
                          input logic [7:0] addr, input logic [7:0] wdata, input int rdy_at,
                          input logic [3:0] exp_wstrb, input logic [3:0] exp_rstrb,
                          input int exp_strb_cyc, input int exp_done_cyc,
                          input logic exp_err, input logic [7:0] exp_data);
      logic [3:0] sel_oh;
      int         strb_cyc;
      bit         seen;
      exp_t       e;
      sel_oh   = exp_wstrb | exp_rstrb;
      strb_cyc = 0;
      seen     = 1'b0;
      e.err    = exp_err;
      e.data   = exp_data;
      sb_q.push_back(e);
      @(negedge i_clk);
      i_peripWrSig       = wr;
      i_peripRdSig       = rd;
      i_peripAddr        = addr;
      i_peripDataFromCPU = wdata;
      i_chReady          = 4'b0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         @(negedge i_clk);
         // Unselected channels report ready throughout; they must be ignored.
         i_chReady = (c == rdy_at) ? sel_oh : ~sel_oh;
         if (o_chWrSig != 4'b0 || o_chRdSig != 4'b0) begin
            strb_cyc++;
            chk({tag, "_wstrb"}, 32'(o_chWrSig), 32'(exp_wstrb));
            chk({tag, "_rstrb"}, 32'(o_chRdSig), 32'(exp_rstrb));
            chk({tag, "_chaddr"}, 32'(o_chAddr), 32'(addr[5:0]));
            if (wr) chk({tag, "_chdata"}, 32'(o_chData), 32'(wdata));
         end
         if (o_peripDone) begin
            seen = 1'b1;
            chk({tag, "_done_cycle"}, 32'(c), 32'(exp_done_cyc));
            chk({tag, "_stall_at_done"}, 32'(o_peripStall), 32'd0);
            i_peripWrSig = 1'b0;
            i_peripRdSig = 1'b0;
         end else begin
            chk({tag, "_stall"}, 32'(o_peripStall), 32'd1);
         end
      end
      i_peripWrSig = 1'b0;
      i_peripRdSig = 1'b0;
      i_chReady    = 4'b0;
      if (!seen) begin
         chk({tag, "_done_timeout"}, 32'd0, 32'd1);
         if (sb_q.size() != 0) void'(sb_q.pop_back());
      end
      chk({tag, "_strobe_cycles"}, 32'(strb_cyc), 32'(exp_strb_cyc));
      @(negedge i_clk);
      chk({tag, "_done_pulse_width"}, 32'(o_peripDone), 32'd0);
   endtask

   task automatic run2(input string tag, input logic wr, input logic rd, input logic [7:0] addr,
                       input logic [1:0] exp_strb, input int exp_done_cyc,
                       input logic exp_err, input logic [7:0] exp_data);
      logic [1:0] acc;
      bit         seen;
      acc  = 2'b0;
      seen = 1'b0;
      @(negedge i_clk);
      b_wr   = wr;
      b_rd   = rd;
      b_addr = addr;
      for (int c = 1; c <= 20 && !seen; c++) begin
         @(negedge i_clk);
         acc = acc | b_chWr | b_chRd;
         if (b_done) begin
            seen = 1'b1;
            chk({tag, "_done_cycle"}, 32'(c), 32'(exp_done_cyc));
            chk({tag, "_err"}, 32'(b_err), 32'(exp_err));
            chk({tag, "_rdata"}, 32'(b_rdata), 32'(exp_data));
            b_wr = 1'b0;
            b_rd = 1'b0;
         end
      end
      b_wr = 1'b0;
      b_rd = 1'b0;
      if (!seen) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
      chk({tag, "_strobes"}, 32'(acc), 32'(exp_strb));
      @(negedge i_clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks           = 0;
      n_errors           = 0;
      i_rst              = 1'b0;
      i_peripAddr        = 8'h00;
      i_peripDataFromCPU = 8'h00;
      i_peripWrSig       = 1'b0;
      i_peripRdSig       = 1'b0;
      i_chData           = {8'h5A, 8'h22, 8'hA5, 8'h11};
      i_chReady          = 4'b0;
      b_addr             = 8'h00;
      b_wdata            = 8'h00;
      b_wr               = 1'b0;
      b_rd               = 1'b0;
      b_chDataIn         = {8'hB1, 8'hB0};
      b_chReady          = 2'b11;

      repeat (3) @(negedge i_clk);
      chk("rst_rdata",  32'(o_peripDataToCPU), 32'd0);
      chk("rst_stall",  32'(o_peripStall), 32'd0);
      chk("rst_done",   32'(o_peripDone), 32'd0);
      chk("rst_err",    32'(o_peripErr), 32'd0);
      chk("rst_wstrb",  32'(o_chWrSig), 32'd0);
      chk("rst_rstrb",  32'(o_chRdSig), 32'd0);
      chk("rst_chaddr", 32'(o_chAddr), 32'd0);
      chk("rst_chdata", 32'(o_chData), 32'd0);
      i_rst = 1'b1;
      @(negedge i_clk);

      run_txn("rd_ch1",      1'b0, 1'b1, 8'h45, 8'h00, 1, 4'b0000, 4'b0010, 1,  2,  1'b0, 8'hA5);
      run_txn("wr_ch2",      1'b1, 1'b0, 8'h82, 8'h3C, 3, 4'b0100, 4'b0000, 3,  4,  1'b0, 8'hA5);
      run_txn("rd_ch3_tmo",  1'b0, 1'b1, 8'hC7, 8'h00, 0, 4'b0000, 4'b1000, 15, 16, 1'b1, 8'hFF);
      run_txn("wr_rd_both",  1'b1, 1'b1, 8'h45, 8'h77, 1, 4'b0000, 4'b0000, 0,  1,  1'b1, 8'hFF);
      run_txn("rd_ch0",      1'b0, 1'b1, 8'h01, 8'h00, 2, 4'b0000, 4'b0001, 2,  3,  1'b0, 8'h11);
      run_txn("wr_ch3_tmo",  1'b1, 1'b0, 8'hFF, 8'h99, 0, 4'b1000, 4'b0000, 15, 16, 1'b1, 8'h11);

      // Reset asserted while a read is waiting on channel 2.
      @(negedge i_clk);
      i_peripRdSig = 1'b1;
      i_peripAddr  = 8'h80;
      repeat (3) @(negedge i_clk);
      chk("mid_rst_pre_rstrb", 32'(o_chRdSig), 32'b0100);
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("mid_rst_rstrb", 32'(o_chRdSig), 32'd0);
      chk("mid_rst_wstrb", 32'(o_chWrSig), 32'd0);
      chk("mid_rst_stall", 32'(o_peripStall), 32'd0);
      chk("mid_rst_done",  32'(o_peripDone), 32'd0);
      chk("mid_rst_err",   32'(o_peripErr), 32'd0);
      i_rst        = 1'b1;
      i_peripRdSig = 1'b0;
      @(negedge i_clk);
      chk("post_rst_rdata", 32'(o_peripDataToCPU), 32'd0);
      chk("post_rst_done",  32'(o_peripDone), 32'd0);
      run_txn("rd_ch0_after_rst", 1'b0, 1'b1, 8'h02, 8'h00, 1, 4'b0000, 4'b0001, 1, 2, 1'b0, 8'h11);

      run2("n2_rd_ch1",   1'b0, 1'b1, 8'h41, 2'b10, 2, 1'b0, 8'hB1);
      run2("n2_both",     1'b1, 1'b1, 8'h41, 2'b00, 1, 1'b1, 8'hB1);
      run2("n2_unmapped", 1'b0, 1'b1, 8'hC0, 2'b00, 1, 1'b1, 8'h00);

      chk("sb_leftover", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
